// File: rtl/m_wb_arbiter2_if.sv
// ---------------------------------------------------------------------------
// m_wb_arbiter2_if : one Wishbone classic link (single master, single slave).
//
// Signals are named from the master's point of view:
//   cyc, stb, we : cycle, strobe, write enable          (master -> slave)
//   adr          : address, AWIDTH bits                 (master -> slave)
//   dat_w        : write data, DWIDTH bits              (master -> slave)
//   sel          : byte select, 4 bits                  (master -> slave)
//   ack          : acknowledge                          (slave -> master)
//   dat_r        : read data, DWIDTH bits               (slave -> master)
//
// Modports:
//   master : the side that drives cyc/stb/we/adr/dat_w/sel
//   slave  : the side that drives ack/dat_r
// ---------------------------------------------------------------------------
interface m_wb_arbiter2_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
) ();

  logic              cyc;
  logic              stb;
  logic              we;
  logic [AWIDTH-1:0] adr;
  logic [DWIDTH-1:0] dat_w;
  logic [3:0]        sel;
  logic              ack;
  logic [DWIDTH-1:0] dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, dat_r
  );

endinterface

// File: rtl/m_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// m_wb_arbiter2 : two-master Wishbone classic arbiter.
//
// Shares one slave port between master 0 (core) and master 1 (loader / debug
// / DMA). The owner keeps the bus for as long as it holds CYC; simultaneous
// requests from idle are resolved round-robin against the previous owner.
//
// Ports:
//   CLK_I  in  1      system clock
//   RST_I  in  1      synchronous, active-high reset
//   m0     slave      master 0 link (CYC/STB/WE/ADR/DAT/SEL in, ACK/DAT out)
//   m1     slave      master 1 link (same as m0)
//   s      master     shared slave link (CYC/STB/WE/ADR/DAT/SEL out, ACK/DAT in)
//   gnt_O  out 2      one-hot registered grant, 00 = idle, 01 = m0, 10 = m1
//   tmo_O  out 1      timeout pulse
//
// Build option:
//   WBARB_TIMEOUT_EN  when defined, an unacknowledged strobe is terminated by
//                     the arbiter after 2**TMOBITS-1 wait cycles: the owner
//                     receives ACK with zero data and tmo_O pulses once.
//                     When undefined, tmo_O is tied low and a strobe waits
//                     for the slave indefinitely.
// ---------------------------------------------------------------------------
module m_wb_arbiter2 #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned TMOBITS = 4
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  m_wb_arbiter2_if.slave        m0,
  m_wb_arbiter2_if.slave        m1,
  m_wb_arbiter2_if.master       s,
  output logic [1:0]            gnt_O,
  output logic                  tmo_O
);

  // One-hot encoding so the state register is the grant vector itself.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_G0   = 2'b01,
    S_G1   = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last;       // most recent owner: 0 = m0, 1 = m1
  logic              w_last_nxt;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_cyc;
  logic              w_stb_raw;    // owner's strobe before timeout masking
  logic              w_we;
  logic [AWIDTH-1:0] w_adr;
  logic [DWIDTH-1:0] w_dat_w;
  logic [3:0]        w_sel;
  logic              w_tmo;

  // A zero-width timeout counter is meaningless.
  if (TMOBITS == 0) begin : g_bad_tmobits
    $error("m_wb_arbiter2: TMOBITS must be at least 1");
  end

  // State and round-robin history register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state: hold while the owner keeps CYC, otherwise hand over directly.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          w_state_nxt = r_last ? S_G0 : S_G1;
        end else if (m0.cyc) begin
          w_state_nxt = S_G0;
        end else if (m1.cyc) begin
          w_state_nxt = S_G1;
        end
      end
      S_G0: begin
        if (!m0.cyc) begin
          w_state_nxt = m1.cyc ? S_G1 : S_IDLE;
        end
      end
      S_G1: begin
        if (!m1.cyc) begin
          w_state_nxt = m0.cyc ? S_G0 : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_state_nxt == S_G0) begin
      w_last_nxt = 1'b0;
    end else if (w_state_nxt == S_G1) begin
      w_last_nxt = 1'b1;
    end
  end

  assign w_gnt0 = (r_state == S_G0);
  assign w_gnt1 = (r_state == S_G1);
  assign gnt_O  = r_state;

  // Request mux toward the slave; everything reads zero while idle.
  always_comb begin
    w_cyc     = 1'b0;
    w_stb_raw = 1'b0;
    w_we      = 1'b0;
    w_adr     = '0;
    w_dat_w   = '0;
    w_sel     = '0;
    if (w_gnt0) begin
      w_cyc     = m0.cyc;
      w_stb_raw = m0.stb;
      w_we      = m0.we;
      w_adr     = m0.adr;
      w_dat_w   = m0.dat_w;
      w_sel     = m0.sel;
    end else if (w_gnt1) begin
      w_cyc     = m1.cyc;
      w_stb_raw = m1.stb;
      w_we      = m1.we;
      w_adr     = m1.adr;
      w_dat_w   = m1.dat_w;
      w_sel     = m1.sel;
    end
  end

`ifdef WBARB_TIMEOUT_EN
  logic [TMOBITS-1:0] r_tmo_cnt;

  // Fires only while the owner is actually strobing, so a master that has
  // already withdrawn STB never receives a phantom acknowledge.
  assign w_tmo = (&r_tmo_cnt) & w_stb_raw & ~s.ack;

  // Counts unacknowledged strobe cycles of the current owner.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_IDLE) || s.ack || w_tmo) begin
      r_tmo_cnt <= '0;
    end else if (w_stb_raw) begin
      r_tmo_cnt <= r_tmo_cnt + TMOBITS'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign s.cyc   = w_cyc;
  assign s.stb   = w_stb_raw & ~w_tmo;
  assign s.we    = w_we;
  assign s.adr   = w_adr;
  assign s.dat_w = w_dat_w;
  assign s.sel   = w_sel;

  // Responses: ACK only to the owner; read data broadcast, zeroed on timeout.
  assign m0.ack   = (s.ack | w_tmo) & w_gnt0;
  assign m1.ack   = (s.ack | w_tmo) & w_gnt1;
  assign m0.dat_r = w_tmo ? '0 : s.dat_r;
  assign m1.dat_r = w_tmo ? '0 : s.dat_r;
  assign tmo_O    = w_tmo;

endmodule

// File: tb/tb_m_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_m_wb_arbiter2 : self-checking bench for m_wb_arbiter2.
// Inputs change 1 ns after the rising edge and outputs are compared 3 ns
// later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_m_wb_arbiter2;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;
  logic       tmo;

  always #5 clk = ~clk;

  m_wb_arbiter2_if #(.AWIDTH(AW), .DWIDTH(DW)) m0 ();
  m_wb_arbiter2_if #(.AWIDTH(AW), .DWIDTH(DW)) m1 ();
  m_wb_arbiter2_if #(.AWIDTH(AW), .DWIDTH(DW)) s ();

  m_wb_arbiter2 #(.DWIDTH(DW), .AWIDTH(AW), .TMOBITS(TMB)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .m0    (m0.slave),
    .m1    (m1.slave),
    .s     (s.master),
    .gnt_O (gnt),
    .tmo_O (tmo)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drv_m0(input logic c, input logic st, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] se);
    m0.cyc = c; m0.stb = st; m0.we = w; m0.adr = a; m0.dat_w = d; m0.sel = se;
  endtask

  task automatic drv_m1(input logic c, input logic st, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] se);
    m1.cyc = c; m1.stb = st; m1.we = w; m1.adr = a; m1.dat_w = d; m1.sel = se;
  endtask

  typedef struct {
    logic       rst;
    logic       m0c, m0s, m1c, m1s, ack;
    logic [1:0] e_gnt;
    logic       e_scyc, e_sstb, e_a0, e_a1;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  // Reference model state: owner -1 = nobody, 0 = m0, 1 = m1.
  int   own, last, cnt;
  logic rc [2];
  logic rs [2];
  logic [31:0] ra [2];
  logic [31:0] rd [2];
  logic [3:0]  rsel [2];
  logic        rwe [2];

  initial begin
    logic [31:0] e_adr;
    logic [3:0]  e_sel;

    rst = 1'b1;
    drv_m0(0, 0, 0, 0, 0, 0);
    drv_m1(0, 0, 0, 0, 0, 0);
    s.ack = 1'b0;
    s.dat_r = '0;

    // ---- reset state ----
    step(); step();
    settle();
    chk("reset gnt", gnt, 2'b00);
    chk("reset s_cyc", s.cyc, 0);
    chk("reset s_stb", s.stb, 0);
    chk("reset s_adr", s.adr, 0);
    chk("reset m0_ack", m0.ack, 0);
    chk("reset m1_ack", m1.ack, 0);
    chk("reset tmo", tmo, 0);
    step();
    rst = 1'b0;

    // ---- table: arbitration, handover, idle ack, reset mid-strobe ----
    //           rst m0c m0s m1c m1s ack  gnt    scyc sstb a0 a1
    tbl[0]  = '{0, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 1, 1, 2'b10, 1, 1, 0, 1};
    tbl[4]  = '{0, 1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1};
    tbl[10] = '{0, 1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 1, 1, 0, 0, 2'b01, 1, 1, 0, 0};
    tbl[12] = '{0, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0};

    for (int i = 0; i < NVEC; i++) begin
      rst = tbl[i].rst;
      drv_m0(tbl[i].m0c, tbl[i].m0s, 1'b1, 32'h100 + 32'(i), 32'hA000 + 32'(i), 4'h3);
      drv_m1(tbl[i].m1c, tbl[i].m1s, 1'b0, 32'h200 + 32'(i), 32'hB000 + 32'(i), 4'hC);
      s.ack   = tbl[i].ack;
      s.dat_r = 32'hD000_0000 + 32'(i);
      settle();
      e_adr = (tbl[i].e_gnt == 2'b01) ? 32'h100 + 32'(i) :
              (tbl[i].e_gnt == 2'b10) ? 32'h200 + 32'(i) : 32'h0;
      e_sel = (tbl[i].e_gnt == 2'b01) ? 4'h3 : (tbl[i].e_gnt == 2'b10) ? 4'hC : 4'h0;
      chk($sformatf("tbl[%0d] gnt", i), gnt, tbl[i].e_gnt);
      chk($sformatf("tbl[%0d] s_cyc", i), s.cyc, tbl[i].e_scyc);
      chk($sformatf("tbl[%0d] s_stb", i), s.stb, tbl[i].e_sstb);
      chk($sformatf("tbl[%0d] m0_ack", i), m0.ack, tbl[i].e_a0);
      chk($sformatf("tbl[%0d] m1_ack", i), m1.ack, tbl[i].e_a1);
      chk($sformatf("tbl[%0d] s_adr", i), s.adr, e_adr);
      chk($sformatf("tbl[%0d] s_sel", i), s.sel, e_sel);
      chk($sformatf("tbl[%0d] s_we", i), s.we, (tbl[i].e_gnt == 2'b01) ? 1'b1 : 1'b0);
      chk($sformatf("tbl[%0d] m1_dat", i), m1.dat_r, 32'hD000_0000 + 32'(i));
      step();
    end
    rst = 1'b0;

    // ---- m0 single read of 0x4, slave acks one cycle after grant ----
    drv_m0(1, 1, 0, 32'h4, 32'h0, 4'hF);
    settle();
    chk("rd gnt before", gnt, 2'b00);
    step(); settle();
    chk("rd gnt", gnt, 2'b01);
    chk("rd s_adr", s.adr, 32'h4);
    chk("rd m0_ack wait", m0.ack, 0);
    step();
    s.ack = 1'b1; s.dat_r = 32'h1234_5678;
    settle();
    chk("rd m0_ack", m0.ack, 1);
    chk("rd m0_dat", m0.dat_r, 32'h1234_5678);
    chk("rd m1_ack", m1.ack, 0);
    step();
    s.ack = 1'b0;
    drv_m0(0, 0, 0, 0, 0, 0);
    step(); settle();
    chk("rd idle", gnt, 2'b00);

    // ---- m1 burst of 3 writes under a competing m0 request ----
    drv_m1(1, 1, 1, 32'h40, 32'hA, 4'hF);
    step();
    for (int k = 0; k < 3; k++) begin
      drv_m1(1, 1, 1, 32'h40 + 32'(4 * k), 32'hA + 32'(k), 4'hF);
      drv_m0(1, 1, 0, 32'h80, 32'h0, 4'hF);
      s.ack = 1'b1;
      settle();
      chk($sformatf("burst%0d gnt", k), gnt, 2'b10);
      chk($sformatf("burst%0d s_dat", k), s.dat_w, 32'hA + 32'(k));
      chk($sformatf("burst%0d s_sel", k), s.sel, 4'hF);
      chk($sformatf("burst%0d m1_ack", k), m1.ack, 1);
      chk($sformatf("burst%0d m0_ack", k), m0.ack, 0);
      step();
    end
    drv_m1(0, 0, 0, 0, 0, 0);
    s.ack = 1'b0;
    settle();
    chk("burst end gnt", gnt, 2'b10);
    chk("burst end s_cyc", s.cyc, 0);
    step(); settle();
    chk("burst handover gnt", gnt, 2'b01);
    chk("burst handover s_adr", s.adr, 32'h80);
    drv_m0(0, 0, 0, 0, 0, 0);
    step(); step();

    // ---- unacknowledged strobe: timeout or indefinite stall ----
    drv_m0(1, 1, 0, 32'hC, 32'h0, 4'hF);
    s.ack = 1'b0; s.dat_r = 32'hFFFF_FFFF;
    step();
`ifdef WBARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      settle();
      chk($sformatf("tmo wait%0d tmo", c), tmo, 0);
      chk($sformatf("tmo wait%0d m0_ack", c), m0.ack, 0);
      step();
    end
    settle();
    chk("tmo fire tmo", tmo, 1);
    chk("tmo fire m0_ack", m0.ack, 1);
    chk("tmo fire m0_dat", m0.dat_r, 32'h0);
    chk("tmo fire s_stb", s.stb, 0);
    step();
    drv_m0(0, 0, 0, 0, 0, 0);
    settle();
    chk("tmo pulse ends", tmo, 0);
`else
    for (int c = 0; c < 100; c++) begin
      settle();
      chk($sformatf("stall%0d tmo", c), tmo, 0);
      chk($sformatf("stall%0d m0_ack", c), m0.ack, 0);
      chk($sformatf("stall%0d s_stb", c), s.stb, 1);
      step();
    end
    drv_m0(0, 0, 0, 0, 0, 0);
`endif
    step(); step();

    // ---- randomized traffic against the reference model ----
    rst = 1'b1;
    step();
    own = -1; last = 1; cnt = 0;
    rc[0] = 0; rc[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      logic        r_rst, r_ack, raw, e_tmo;
      logic [31:0] r_dat;
      int          req;

      r_rst = ($urandom_range(63) == 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(3) == 0) rc[m] = ~rc[m];
        rs[m]   = rc[m] & ($urandom_range(3) != 0);
        rwe[m]  = 1'($urandom_range(1));
        ra[m]   = $urandom;
        rd[m]   = $urandom;
        rsel[m] = 4'($urandom_range(15));
      end
      r_ack = ($urandom_range(2) == 0);
      r_dat = $urandom;

      rst = r_rst;
      drv_m0(rc[0], rs[0], rwe[0], ra[0], rd[0], rsel[0]);
      drv_m1(rc[1], rs[1], rwe[1], ra[1], rd[1], rsel[1]);
      s.ack = r_ack; s.dat_r = r_dat;
      settle();

      raw = (own >= 0) ? rs[own] : 1'b0;
`ifdef WBARB_TIMEOUT_EN
      e_tmo = (cnt == (1 << TMB) - 1) && raw && !r_ack;
`else
      e_tmo = 1'b0;
`endif
      chk("rnd gnt", gnt, {own == 1, own == 0});
      chk("rnd s_cyc", s.cyc, (own >= 0) ? rc[own] : 1'b0);
      chk("rnd s_stb", s.stb, raw && !e_tmo);
      chk("rnd s_we", s.we, (own >= 0) ? rwe[own] : 1'b0);
      chk("rnd s_adr", s.adr, (own >= 0) ? ra[own] : 32'h0);
      chk("rnd s_dat", s.dat_w, (own >= 0) ? rd[own] : 32'h0);
      chk("rnd s_sel", s.sel, (own >= 0) ? rsel[own] : 4'h0);
      chk("rnd m0_ack", m0.ack, (own == 0) && (r_ack || e_tmo));
      chk("rnd m1_ack", m1.ack, (own == 1) && (r_ack || e_tmo));
      chk("rnd m0_dat", m0.dat_r, e_tmo ? 32'h0 : r_dat);
      chk("rnd m1_dat", m1.dat_r, e_tmo ? 32'h0 : r_dat);
      chk("rnd tmo", tmo, e_tmo);

      // Advance the model across the coming edge.
      if (r_rst) begin
        own = -1; last = 1; cnt = 0;
      end else begin
        if (own < 0 || r_ack || e_tmo) cnt = 0;
        else if (raw) cnt = cnt + 1;
        if (!(own >= 0 && rc[own])) begin
          req = (rc[0] ? 1 : 0) + (rc[1] ? 2 : 0);
          if (req == 3)      own = 1 - last;
          else if (req == 1) own = 0;
          else if (req == 2) own = 1;
          else               own = -1;
          if (own < 0) cnt = 0;
        end
        if (own >= 0) last = own;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/m_wb_arbiter2.md
Name: m_wb_arbiter2

Overview:
- Two-master Wishbone classic arbiter for midgetv systems.
- Shares one slave port (e.g. m_whishbonereg, or an EBR/SRAM bridge) between the core's bus master (m0) and a second master (m1: loader/debug/DMA).
- Ownership is held for as long as the owner keeps CYC high; contention is resolved round-robin.
- Sits between m_midgetv_core, the second master and the slave address decode.

Parameters:
- DWIDTH, 32, data width of all data buses.
- AWIDTH, 32, address width.
- TMOBITS, 4, timeout counter width; timeout fires after 2**TMOBITS-1 unacknowledged strobe cycles (only with WBARB_TIMEOUT_EN).

Ports:
- CLK_I in 1: single system clock.
- RST_I in 1: synchronous, active-high reset.
- m0_CYC_I, m0_STB_I, m0_WE_I in 1 each: master 0 cycle, strobe, write enable.
- m0_ADR_I in AWIDTH: master 0 address.
- m0_DAT_I in DWIDTH: master 0 write data.
- m0_SEL_I in 4: master 0 byte select.
- m0_ACK_O out 1: acknowledge to master 0.
- m0_DAT_O out DWIDTH: read data to master 0.
- m1_* in/out, same set and widths as m0_*: master 1.
- s_CYC_O, s_STB_O, s_WE_O out 1 each: slave cycle, strobe, write enable.
- s_ADR_O out AWIDTH: slave address.
- s_DAT_O out DWIDTH: slave write data.
- s_SEL_O out 4: slave byte select.
- s_ACK_I in 1: slave acknowledge.
- s_DAT_I in DWIDTH: slave read data.
- gnt_O out 2: one-hot registered grant, 00 = idle.
- tmo_O out 1: timeout pulse.

Behaviour:
- State register, three states: IDLE (gnt 00), G0 (gnt 01), G1 (gnt 10). last register holds the most recent owner.
- Reset (synchronous): state IDLE, last = 1 (so m0 wins the first contention), timeout counter 0. All outputs deasserted: gnt_O = 00, s_* = 0, m*_ACK_O = 0, tmo_O = 0.
- IDLE transitions:
  - Only m0_CYC_I → G0.
  - Only m1_CYC_I → G1.
  - Both → grant the master not equal to last.
  - Neither → stay IDLE.
- Gx transitions:
  - mx_CYC_I high → stay; the grant is locked for the whole CYC, including multiple STB beats.
  - mx_CYC_I low, other master requesting → direct handover to G(other), no idle cycle.
  - mx_CYC_I low, no other request → IDLE.
  - last ← x on entry to Gx.
- Latency: the grant is registered, so a request seen in IDLE at edge n drives the slave port from cycle n+1. Switching from G0 to G1 costs one cycle after m0 drops CYC.
- Slave mux is combinational from the granted master:
  - s_CYC_O = mx_CYC_I & gnt[x]; s_STB_O = mx_STB_I & gnt[x].
  - ADR/DAT/SEL/WE are taken from the granted master; all zero in IDLE.
- Response routing:
  - mx_ACK_O = s_ACK_I & gnt[x]. A non-granted master never sees ACK.
  - s_DAT_I is broadcast to both m*_DAT_O; validity is qualified only by ACK.
- Owner drops CYC while STB is pending without ACK: s_CYC_O/s_STB_O fall in the same cycle (abort is visible to the slave), and the state transitions per the rules above at the next edge.
- Any ACK arriving while IDLE is ignored and not routed.
- Reset asserted mid-transaction: IDLE at the next edge regardless of CYC; a pending transfer is abandoned without ACK.
- Simultaneous owner-CYC-drop and new requests by both masters: the other master wins (last = current owner).

Optional Feature:
- Macro WBARB_TIMEOUT_EN.
- Defined:
  - TMOBITS counter increments each cycle s_STB_O & ~s_ACK_I and clears on s_ACK_I, in IDLE, or on timeout.
  - When the count equals 2**TMOBITS-1 and s_ACK_I is low, that cycle:
    - the owner's mx_ACK_O = 1 and m*_DAT_O = 0;
    - s_STB_O is forced 0;
    - tmo_O = 1 (one-cycle pulse).
  - The master thus completes its transfer and can drop CYC.
- Not defined: no counter is present, tmo_O is tied 0, and an unacknowledged strobe waits indefinitely.

Test Plan:
- Reset, then m0 single read of ADR 0x0000_0004, slave ACKs one cycle later with 0x1234_5678 → gnt_O = 01 one cycle after CYC; m0_ACK_O = 1 with m0_DAT_O = 0x1234_5678; m1_ACK_O stays 0.
- m0 and m1 raise CYC in the same cycle right after reset → m0 granted first. After m0 drops CYC, gnt_O = 10 on the next edge. The next simultaneous request goes to m0 again (alternation holds over 4 rounds).
- m1 holds CYC for 3 STB beats, writing 0xA/0xB/0xC with SEL = 4'hF while m0 requests → m1 keeps the grant through all 3 ACKs; m0 is granted only after m1 drops CYC, with zero cycles in IDLE.
- RST_I pulsed one cycle while m0 is mid-strobe with no ACK → gnt_O = 00 and s_CYC_O = 0 after the edge; when m0 keeps CYC high after reset, it is re-granted one cycle later.
- WBARB_TIMEOUT_EN with TMOBITS = 4, slave never ACKs → after 15 strobe cycles: m0_ACK_O = 1, m0_DAT_O = 0, tmo_O = 1 for exactly one cycle. Without the macro, m0 remains stalled for 100 cycles and tmo_O stays 0.
